sonar_rx_frame: RTL and testbench

Host-side receiver for the sonar's serial telemetry. It deserialises the UART stream that the sonar control unit transmits after each measurement and parses each ASCII frame `AAA,DDDD#`. Each frame carries a 3-digit angle and a 4-digit distance. The block presents both values as BCD with a one-cycle valid strobe, and it sits between the `rx` pin and the display/host logic on the receiving board.

---
 rtl/sonar_pkg.sv | 36 +++
 rtl/sonar_rx_serial.sv | 140 ++++++++++++++
 rtl/sonar_rx_frame.sv | 160 ++++++++++++++++
 tb/tb_sonar_rx_frame.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared constants and state encodings for the sonar telemetry receiver.
// Optional parity checking is selected with SONAR_RX_PARITY_CHECK_EN.
package sonar_pkg;

    localparam logic [6:0] CHAR_ZERO      = 7'h30;
    localparam logic [6:0] CHAR_NOVE      = 7'h39;
    localparam logic [6:0] CHAR_VIRGULA   = 7'h2C;
    localparam logic [6:0] CHAR_CERQUILHA = 7'h23;

    localparam int N_DIG_ANG  = 3;
    localparam int N_DIG_DIST = 4;

    typedef enum logic [2:0] {
        SER_REPOUSO,
        SER_START,
        SER_DADOS,
        SER_PARIDADE,
        SER_STOP,
        SER_ESPERA_ALTO
    } ser_estado_t;

    typedef enum logic [3:0] {
        P_ESPERA = 4'h0,
        P_ANG    = 4'h1,
        P_VIRG   = 4'h2,
        P_DIST   = 4'h3,
        P_FIM    = 4'h4,
        P_VALIDO = 4'h5,
        P_ERRO   = 4'hE
    } par_estado_t;

    function automatic logic eh_digito(input logic [6:0] c);
        return (c >= CHAR_ZERO) && (c <= CHAR_NOVE);
    endfunction

endpackage

// File: rtl/sonar_rx_serial.sv
// 7O1 UART deserialiser: synchroniser, bit timer and bit-level FSM.
// SONAR_RX_PARITY_CHECK_EN enables rejection of characters with bad parity.
module sonar_rx_serial
    import sonar_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [6:0] char_o,
    output logic       char_pronto,
    output logic       char_erro
);

    localparam int BIT_TICKS = CLK_FREQ / BAUD;
    localparam int CW        = $clog2(BIT_TICKS + 1);
    localparam logic [CW-1:0] FIM_BIT  = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] FIM_MEIO = CW'(BIT_TICKS / 2 - 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    ser_estado_t   estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    nbit_q, nbit_d;
    logic [6:0]    dados_q, dados_d;
    logic          pronto_q, pronto_d;
    logic          erro_q, erro_d;
    logic          linha;

    assign linha = sync_q[1];

`ifdef SONAR_RX_PARITY_CHECK_EN
    logic par_ok_q, par_ok_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) par_ok_q <= 1'b0;
        else       par_ok_q <= par_ok_d;
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q   <= 2'b11;
            prev_q   <= 1'b1;
            estado_q <= SER_REPOUSO;
            cnt_q    <= '0;
            nbit_q   <= '0;
            dados_q  <= '0;
            pronto_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], rx};
            prev_q   <= linha;
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            nbit_q   <= nbit_d;
            dados_q  <= dados_d;
            pronto_q <= pronto_d;
            erro_q   <= erro_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        nbit_d   = nbit_q;
        dados_d  = dados_q;
        pronto_d = 1'b0;
        erro_d   = 1'b0;
`ifdef SONAR_RX_PARITY_CHECK_EN
        par_ok_d = par_ok_q;
`endif
        unique case (estado_q)
            SER_REPOUSO: begin
                cnt_d = '0;
                if (prev_q && !linha) estado_d = SER_START;
            end
            SER_START: begin
                if (cnt_q == FIM_MEIO) begin
                    cnt_d    = '0;
                    nbit_d   = '0;
                    estado_d = linha ? SER_REPOUSO : SER_DADOS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SER_DADOS: begin
                if (cnt_q == FIM_BIT) begin
                    cnt_d   = '0;
                    dados_d = {linha, dados_q[6:1]};
                    if (nbit_q == 3'd6) estado_d = SER_PARIDADE;
                    else                nbit_d   = nbit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SER_PARIDADE: begin
                if (cnt_q == FIM_BIT) begin
                    cnt_d    = '0;
                    estado_d = SER_STOP;
`ifdef SONAR_RX_PARITY_CHECK_EN
                    par_ok_d = ^{dados_q, linha};
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SER_STOP: begin
                if (cnt_q == FIM_BIT) begin
                    cnt_d = '0;
                    if (linha) begin
                        estado_d = SER_REPOUSO;
`ifdef SONAR_RX_PARITY_CHECK_EN
                        pronto_d = par_ok_q;
                        erro_d   = !par_ok_q;
`else
                        pronto_d = 1'b1;
`endif
                    end else begin
                        erro_d   = 1'b1;
                        estado_d = SER_ESPERA_ALTO;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SER_ESPERA_ALTO: begin
                if (linha) estado_d = SER_REPOUSO;
            end
            default: estado_d = SER_REPOUSO;
        endcase
    end

    assign char_o      = dados_q;
    assign char_pronto = pronto_q;
    assign char_erro   = erro_q;

endmodule

// File: rtl/sonar_rx_frame.sv
// Parser for "AAA,DDDD#" telemetry frames on top of the serial receiver.
// Build option SONAR_RX_PARITY_CHECK_EN is forwarded to sonar_rx_serial.
module sonar_rx_frame
    import sonar_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    output logic [11:0] angulo,
    output logic [15:0] distancia,
    output logic        frame_valido,
    output logic        erro_frame,
    output logic [3:0]  db_estado
);

    logic [6:0] char_w;
    logic       char_pronto;
    logic       char_erro;

    sonar_rx_serial #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_serial (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .char_o      (char_w),
        .char_pronto (char_pronto),
        .char_erro   (char_erro)
    );

    par_estado_t estado_q, estado_d;
    logic [2:0]  idx_q, idx_d;
    logic [11:0] ang_sh_q, ang_sh_d;
    logic [15:0] dist_sh_q, dist_sh_d;
    logic [11:0] ang_q, ang_d;
    logic [15:0] dist_q, dist_d;
    logic        fv_q, fv_d;
    logic        ef_q, ef_d;
    logic        descarta_q, descarta_d;
    logic        dig, eh_cerq, aborta;
    logic [3:0]  nib;

    assign dig     = eh_digito(char_w);
    assign eh_cerq = (char_w == CHAR_CERQUILHA);
    assign nib     = char_w[3:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= P_ESPERA;
            idx_q      <= '0;
            ang_sh_q   <= '0;
            dist_sh_q  <= '0;
            ang_q      <= '0;
            dist_q     <= '0;
            fv_q       <= 1'b0;
            ef_q       <= 1'b0;
            descarta_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            idx_q      <= idx_d;
            ang_sh_q   <= ang_sh_d;
            dist_sh_q  <= dist_sh_d;
            ang_q      <= ang_d;
            dist_q     <= dist_d;
            fv_q       <= fv_d;
            ef_q       <= ef_d;
            descarta_q <= descarta_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        idx_d      = idx_q;
        ang_sh_d   = ang_sh_q;
        dist_sh_d  = dist_sh_q;
        ang_d      = ang_q;
        dist_d     = dist_q;
        fv_d       = 1'b0;
        ef_d       = 1'b0;
        descarta_d = descarta_q;
        aborta     = 1'b0;
        unique case (estado_q)
            P_ESPERA: begin
                // After an abort, skip the rest of the broken frame up to '#'.
                if (descarta_q) begin
                    if (char_pronto && eh_cerq) descarta_d = 1'b0;
                end else if (char_pronto && dig) begin
                    ang_sh_d[11:8] = nib;
                    idx_d          = 3'd1;
                    estado_d       = P_ANG;
                end
            end
            P_ANG: begin
                if (char_erro || (char_pronto && !dig)) begin
                    aborta = 1'b1;
                end else if (char_pronto) begin
                    if (idx_q == 3'd1) ang_sh_d[7:4] = nib;
                    else               ang_sh_d[3:0] = nib;
                    if (idx_q == 3'(N_DIG_ANG - 1)) estado_d = P_VIRG;
                    else                            idx_d    = idx_q + 1'b1;
                end
            end
            P_VIRG: begin
                if (char_erro || (char_pronto && char_w != CHAR_VIRGULA)) begin
                    aborta = 1'b1;
                end else if (char_pronto) begin
                    idx_d    = '0;
                    estado_d = P_DIST;
                end
            end
            P_DIST: begin
                if (char_erro || (char_pronto && !dig)) begin
                    aborta = 1'b1;
                end else if (char_pronto) begin
                    unique case (idx_q)
                        3'd0:    dist_sh_d[15:12] = nib;
                        3'd1:    dist_sh_d[11:8]  = nib;
                        3'd2:    dist_sh_d[7:4]   = nib;
                        default: dist_sh_d[3:0]   = nib;
                    endcase
                    if (idx_q == 3'(N_DIG_DIST - 1)) estado_d = P_FIM;
                    else                             idx_d    = idx_q + 1'b1;
                end
            end
            P_FIM: begin
                if (char_erro || (char_pronto && !eh_cerq)) begin
                    aborta = 1'b1;
                end else if (char_pronto) begin
                    estado_d = P_VALIDO;
                end
            end
            P_VALIDO: begin
                ang_d    = ang_sh_q;
                dist_d   = dist_sh_q;
                fv_d     = 1'b1;
                estado_d = P_ESPERA;
            end
            P_ERRO: begin
                ef_d     = 1'b1;
                estado_d = P_ESPERA;
            end
            default: estado_d = P_ESPERA;
        endcase
        if (aborta) begin
            estado_d   = P_ERRO;
            descarta_d = !(char_pronto && eh_cerq);
        end
    end

    assign angulo       = ang_q;
    assign distancia    = dist_q;
    assign frame_valido = fv_q;
    assign erro_frame   = ef_q;
    assign db_estado    = estado_q;

endmodule

// File: tb/tb_sonar_rx_frame.sv
// Self-checking bench for sonar_rx_frame: directed frames plus random
// frames compared against a template-matching reference model.
module tb_sonar_rx_frame;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BT       = CLK_FREQ / BAUD;
`ifdef SONAR_RX_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx    = 1'b1;
    logic [11:0] angulo;
    logic [15:0] distancia;
    logic        frame_valido;
    logic        erro_frame;
    logic [3:0]  db_estado;

    sonar_rx_frame #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .angulo       (angulo),
        .distancia    (distancia),
        .frame_valido (frame_valido),
        .erro_frame   (erro_frame),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [27:0] got_q[$];
    int got_err = 0;
    int fv_run  = 0;
    int fv_max  = 0;

    always @(negedge clock) begin
        if (reset) begin
            fv_run = 0;
        end else if (frame_valido) begin
            fv_run++;
            if (fv_run > fv_max) fv_max = fv_run;
            if (fv_run == 1) got_q.push_back({angulo, distancia});
        end else begin
            fv_run = 0;
        end
        if (!reset && erro_frame) got_err++;
    end

    // Reference model: match characters against the frame template.
    string       TMPL = "DDD,DDDD#";
    int          m_pos;
    bit          m_skip;
    logic [3:0]  m_dig[7];
    logic [27:0] m_last;
    logic [27:0] exp_q[$];
    int          exp_err;

    function automatic void model_reset();
        m_pos   = 0;
        m_skip  = 0;
        m_last  = '0;
        exp_err = 0;
        exp_q.delete();
    endfunction

    function automatic void model_char(input byte c, input bit cerr);
        bit  is_d;
        bit  match;
        byte t;
        is_d  = (c >= 8'h30) && (c <= 8'h39);
        t     = TMPL[m_pos];
        match = (t == 8'h44) ? is_d : (c == t);
        if (m_pos == 0) begin
            if (m_skip) begin
                if (!cerr && c == 8'h23) m_skip = 0;
            end else if (!cerr && is_d) begin
                m_dig[0] = c[3:0];
                m_pos    = 1;
            end
        end else if (!cerr && match) begin
            if (t == 8'h44) m_dig[(m_pos < 3) ? m_pos : m_pos - 1] = c[3:0];
            m_pos++;
            if (m_pos == 9) begin
                m_last = {m_dig[0], m_dig[1], m_dig[2],
                          m_dig[3], m_dig[4], m_dig[5], m_dig[6]};
                exp_q.push_back(m_last);
                m_pos = 0;
            end
        end else begin
            exp_err++;
            m_pos  = 0;
            m_skip = !(!cerr && c == 8'h23);
        end
    endfunction

    task automatic send_char(input byte c, input bit bad_par, input int nbits);
        logic [9:0] f;
        logic [6:0] d;
        d = c[6:0];
        f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = f[i];
            repeat (BT) @(negedge clock);
        end
    endtask

    task automatic send_str(input string s, input int bad_idx);
        byte b;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            send_char(b, i == bad_idx, 10);
        end
    endtask

    task automatic clear_obs();
        got_q.delete();
        got_err = 0;
        fv_max  = 0;
    endtask

    task automatic settle();
        rx = 1'b1;
        repeat (3 * BT) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clock);
        checks++; if (angulo !== 12'h000) begin failures++;
            $display("FAIL reset_angulo got=%h exp=000", angulo); end
        checks++; if (distancia !== 16'h0000) begin failures++;
            $display("FAIL reset_distancia got=%h exp=0000", distancia); end
        checks++; if (frame_valido !== 1'b0) begin failures++;
            $display("FAIL reset_frame_valido got=%b exp=0", frame_valido); end
        checks++; if (erro_frame !== 1'b0) begin failures++;
            $display("FAIL reset_erro_frame got=%b exp=0", erro_frame); end
        checks++; if (db_estado !== 4'h0) begin failures++;
            $display("FAIL reset_db_estado got=%h exp=0", db_estado); end
        reset = 1'b0;
        repeat (2 * BT) @(negedge clock);
    endtask

    task automatic test_frame();
        clear_obs();
        send_str("090,0123#", -1);
        settle();
        checks++; if (got_q.size() !== 1) begin failures++;
            $display("FAIL frame_count got=%0d exp=1", got_q.size()); end
        checks++; if (angulo !== 12'h090 || distancia !== 16'h0123) begin failures++;
            $display("FAIL frame_value got=%h/%h exp=090/0123", angulo, distancia); end
        checks++; if (fv_max !== 1) begin failures++;
            $display("FAIL frame_pulse_width got=%0d exp=1", fv_max); end
        checks++; if (got_err !== 0) begin failures++;
            $display("FAIL frame_errors got=%0d exp=0", got_err); end
    endtask

    task automatic test_abort();
        clear_obs();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (BT) @(negedge clock);
        send_str("09,0123#", -1);
        settle();
        checks++; if (got_err !== 1) begin failures++;
            $display("FAIL abort_errors got=%0d exp=1", got_err); end
        checks++; if (angulo !== 12'h000 || distancia !== 16'h0000) begin failures++;
            $display("FAIL abort_hold got=%h/%h exp=000/0000", angulo, distancia); end
        send_str("045,0200#", -1);
        settle();
        checks++; if (got_q.size() !== 1 || got_err !== 1) begin failures++;
            $display("FAIL abort_recover_count got=%0d/%0d exp=1/1", got_q.size(), got_err); end
        checks++; if (angulo !== 12'h045 || distancia !== 16'h0200) begin failures++;
            $display("FAIL abort_recover_value got=%h/%h exp=045/0200", angulo, distancia); end
    endtask

    task automatic test_parity();
        logic [27:0] exp_val;
        int          exp_e;
        clear_obs();
        send_str("180,0050#", 7);
        settle();
        exp_val = PAR_EN ? 28'h0450200 : 28'h1800050;
        exp_e   = PAR_EN ? 1 : 0;
        checks++; if (got_err !== exp_e) begin failures++;
            $display("FAIL parity_errors got=%0d exp=%0d", got_err, exp_e); end
        checks++; if (got_q.size() !== 1 - exp_e) begin failures++;
            $display("FAIL parity_count got=%0d exp=%0d", got_q.size(), 1 - exp_e); end
        checks++; if ({angulo, distancia} !== exp_val) begin failures++;
            $display("FAIL parity_value got=%h exp=%h", {angulo, distancia}, exp_val); end
    endtask

    task automatic test_reset_mid();
        byte b;
        string s;
        clear_obs();
        s = "123,4567#";
        for (int i = 0; i < 5; i++) begin
            b = s[i];
            send_char(b, 1'b0, 10);
        end
        checks++; if (db_estado !== 4'h3) begin failures++;
            $display("FAIL midframe_state got=%h exp=3", db_estado); end
        b = s[5];
        send_char(b, 1'b0, 4);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (angulo !== 12'h000 || distancia !== 16'h0000) begin failures++;
            $display("FAIL midreset_outputs got=%h/%h exp=000/0000", angulo, distancia); end
        checks++; if (db_estado !== 4'h0) begin failures++;
            $display("FAIL midreset_state got=%h exp=0", db_estado); end
        reset = 1'b0;
        repeat (2 * BT) @(negedge clock);
        send_str("030,0010#", -1);
        settle();
        checks++; if (got_q.size() !== 1 || got_err !== 0) begin failures++;
            $display("FAIL midreset_count got=%0d/%0d exp=1/0", got_q.size(), got_err); end
        checks++; if (angulo !== 12'h030 || distancia !== 16'h0010) begin failures++;
            $display("FAIL midreset_value got=%h/%h exp=030/0010", angulo, distancia); end
    endtask

    task automatic test_glitch();
        clear_obs();
        rx = 1'b0;
        repeat (BT / 4) @(negedge clock);
        rx = 1'b1;
        repeat (2 * BT) @(negedge clock);
        checks++; if (db_estado !== 4'h0) begin failures++;
            $display("FAIL glitch_state got=%h exp=0", db_estado); end
        send_str("000,0000#", -1);
        settle();
        checks++; if (got_q.size() !== 1 || got_err !== 0) begin failures++;
            $display("FAIL glitch_count got=%0d/%0d exp=1/0", got_q.size(), got_err); end
        checks++; if (got_q.size() > 0 && got_q[0] !== 28'h0000000) begin failures++;
            $display("FAIL glitch_value got=%h exp=0000000", got_q[0]); end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        send_str("111,2222#987,6543#", -1);
        settle();
        checks++; if (got_q.size() !== 2 || got_err !== 0) begin failures++;
            $display("FAIL b2b_count got=%0d/%0d exp=2/0", got_q.size(), got_err); end
        checks++; if (got_q.size() > 0 && got_q[0] !== 28'h1112222) begin failures++;
            $display("FAIL b2b_first got=%h exp=1112222", got_q[0]); end
        checks++; if (got_q.size() > 1 && got_q[1] !== 28'h9876543) begin failures++;
            $display("FAIL b2b_second got=%h exp=9876543", got_q[1]); end
        checks++; if (fv_max !== 1) begin failures++;
            $display("FAIL b2b_pulse_width got=%0d exp=1", fv_max); end
    endtask

    task automatic test_random();
        string pool;
        byte   fr[$];
        int    mode, pos, bad;
        byte   b;
        pool = "0,#A5";
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        clear_obs();
        model_reset();
        repeat (BT) @(negedge clock);
        for (int f = 0; f < 14; f++) begin
            fr.delete();
            for (int i = 0; i < 9; i++) begin
                b = TMPL[i];
                if (b == 8'h44) b = 8'(8'h30 + $urandom_range(0, 9));
                fr.push_back(b);
            end
            mode = $urandom_range(0, 3);
            pos  = $urandom_range(0, 8);
            bad  = -1;
            if (mode == 1) fr[pos] = pool[$urandom_range(0, 4)];
            if (mode == 2) fr.delete(pos);
            if (mode == 3) bad = pos;
            for (int i = 0; i < fr.size(); i++) begin
                send_char(fr[i], i == bad, 10);
                model_char(fr[i], PAR_EN && (i == bad));
            end
            repeat ($urandom_range(0, 2 * BT)) @(negedge clock);
        end
        settle();
        checks++; if (got_q.size() !== exp_q.size()) begin failures++;
            $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++;
                $display("FAIL rand_frame%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (got_err !== exp_err) begin failures++;
            $display("FAIL rand_errors got=%0d exp=%0d", got_err, exp_err); end
        checks++; if ({angulo, distancia} !== m_last) begin failures++;
            $display("FAIL rand_last got=%h exp=%h", {angulo, distancia}, m_last); end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_frame();
        test_abort();
        test_parity();
        test_reset_mid();
        test_glitch();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
